alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multicycle ALU for the MIPS datapath, the successor to the 3-bit-op combinational ALU.
//  Adds shifts, signed SLT, flags and an iterative unsigned multiplier behind a start/done handshake.
//  Sits in the EX stage; the control FSM holds EX until done.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4, power of 2)
//  SHW     $clog2(WIDTH)  shift-amount bits taken from b[SHW-1:0] (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous, active-low reset
//  start      in   1      request; sampled only while busy==0
//  alu_op     in   4      operation code (see BEHAVIOUR)
//  a          in   WIDTH  operand A (captured on accepted start)
//  b          in   WIDTH  operand B / shift amount (captured on accepted start)
//  busy       out  1      1 from the cycle after acceptance until done
//  done       out  1      one-cycle pulse; result/flags valid from this cycle
//  result     out  WIDTH  low result; held until next accepted start
//  result_hi  out  WIDTH  MULTU high word / DIVU remainder; 0 for other ops
//  zero       out  1      result==0 (registered with result)
//  overflow   out  1      signed overflow for ADD/SUB; DIVU divide-by-zero; else 0
//  illegal    out  1      undefined alu_op; registered with done
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, result=0, result_hi=0, zero=1, overflow=0, illegal=0. Reset mid-op aborts; no done.
//  - Ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1111 SLTU,
//    0011 SLL, 0100 SRL, 0101 SRA (shift b[SHW-1:0]), 1000 MULTU, 1001 DIVU (macro-gated).
//  - Illegal op: result=0, result_hi=0, zero=1, illegal=1; single-cycle timing.
//  - FSM: IDLE -(start, single-cycle op)-> DONE; IDLE -(start, MULTU/DIVU)-> ITER;
//    ITER -(count==WIDTH-1)-> DONE; DONE -> IDLE unconditionally.
//  - Single-cycle ops: start sampled in cycle N -> done=1 in cycle N+1.
//  - MULTU: radix-2 shift-add, one bit/cycle; done in cycle N+WIDTH+1; {result_hi,result}=a*b (2*WIDTH, unsigned).
//  - DIVU: restoring, one bit/cycle, same latency as MULTU; result=a/b, result_hi=a%b.
//    b==0: result=all ones, result_hi=a, overflow=1; full latency preserved.
//  - ADD/SUB wrap modulo 2^WIDTH; overflow = signed overflow; carry not reported.
//  - busy=1 in ITER and DONE; start while busy ignored (no queueing, inputs not re-captured).
//  - start in the DONE cycle is ignored; earliest back-to-back acceptance is the cycle after done.
//  - Operands latched at acceptance; later a/b/alu_op changes have no effect on the op in flight.
//  - done is high exactly one cycle per accepted op; outputs stable otherwise.
// CONFIGURATION
//  ALU_DIV_EN defined: DIVU (1001) implemented as above, sharing the ITER counter and datapath registers.
//  ALU_DIV_EN undefined: 1001 treated as illegal (single-cycle, illegal=1); no divider logic synthesised.
// TESTING (WIDTH=32)
//  ADD a=7FFFFFFF b=1 -> done at N+1, result=80000000, overflow=1, zero=0.
//  SUB a=5 b=5 -> result=0, zero=1; SLT a=FFFFFFFF b=1 -> 1; SLTU same operands -> 0.
//  SRA a=80000000 b=4 -> F8000000; SRL same -> 08000000; SLL a=1 b=31 -> 80000000.
//  MULTU a=FFFFFFFF b=FFFFFFFF -> done at N+33, result_hi=FFFFFFFE, result=00000001; start pulses mid-op ignored.
//  DIVU (ALU_DIV_EN) a=100 b=7 -> result=24, result_hi=4; b=0 -> result=FFFFFFFF, result_hi=a, overflow=1; undefined macro -> illegal=1.
//  reset_n low during MULTU iteration 10 -> next cycle busy=0, done=0, result=0; new ADD then completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multicycle ALU for the EX stage of the MIPS datapath.
// Single-cycle ops (logic, add/sub, set-less-than, shifts) complete one cycle
// after acceptance; MULTU (and DIVU when ALU_DIV_EN is defined) iterate one
// bit per cycle over WIDTH cycles. Without ALU_DIV_EN, op 1001 is illegal
// and no divider logic is built.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ITER = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif
    localparam logic [3:0] OP_SLTU  = 4'b1111;

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // acc_hi/acc_lo: product high/low for MULTU, remainder/quotient for DIVU
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // opd: multiplicand for MULTU, divisor for DIVU
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
`ifdef ALU_DIV_EN
    logic             op_div_q, op_div_d;
    logic             is_div_s;
    logic [WIDTH:0]   div_sh_s;
    logic [WIDTH:0]   div_diff_s;
`endif

    logic [WIDTH-1:0] sc_res_s;
    logic             sc_ovf_s;
    logic             sc_ill_s;
    logic             is_iter_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;

    assign sum_s   = a + b;
    assign diff_s  = a - b;
    assign shamt_s = b[SHW-1:0];

    // Decode the requested op and compute single-cycle results from live operands
    always_comb begin
        sc_res_s  = {WIDTH{1'b0}};
        sc_ovf_s  = 1'b0;
        sc_ill_s  = 1'b0;
        is_iter_s = 1'b0;
`ifdef ALU_DIV_EN
        is_div_s  = 1'b0;
`endif
        case (alu_op)
            OP_AND:   sc_res_s = a & b;
            OP_OR:    sc_res_s = a | b;
            OP_ADD: begin
                sc_res_s = sum_s;
                sc_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = diff_s;
                sc_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:   sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  sc_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:   sc_res_s = a << shamt_s;
            OP_SRL:   sc_res_s = a >> shamt_s;
            OP_SRA:   sc_res_s = $unsigned($signed(a) >>> shamt_s);
            OP_MULTU: is_iter_s = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                is_iter_s = 1'b1;
                is_div_s  = 1'b1;
            end
`endif
            default:  sc_ill_s = 1'b1;
        endcase
    end

    // One iteration step: shift-add multiply, or restoring divide when enabled
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_DIV_EN
        div_sh_s   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, opd_q};
        if (op_div_q) begin
            if (div_sh_s >= {1'b0, opd_q}) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_sh_s[WIDTH-1:0];
                step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        end
`else
        step_hi_s = mul_sum_s[WIDTH:1];
        step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
`endif
    end

    // Control FSM and output/datapath next-state; outputs change only on completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opd_d       = opd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
`ifdef ALU_DIV_EN
        op_div_d    = op_div_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_s) begin
                        state_d  = ST_ITER;
                        cnt_d    = {SHW{1'b0}};
                        acc_hi_d = {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
                        op_div_d = is_div_s;
                        if (is_div_s) begin
                            acc_lo_d = a;
                            opd_d    = b;
                        end else begin
                            acc_lo_d = b;
                            opd_d    = a;
                        end
`else
                        acc_lo_d = b;
                        opd_d    = a;
`endif
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = sc_res_s;
                        result_hi_d = {WIDTH{1'b0}};
                        zero_d      = (sc_res_s == {WIDTH{1'b0}});
                        ovf_d       = sc_ovf_s;
                        illegal_d   = sc_ill_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                acc_hi_d = step_hi_s;
                acc_lo_d = step_lo_s;
                cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    result_d    = step_lo_s;
                    result_hi_d = step_hi_s;
                    zero_d      = (step_lo_s == {WIDTH{1'b0}});
                    illegal_d   = 1'b0;
`ifdef ALU_DIV_EN
                    ovf_d       = op_div_q && (opd_q == {WIDTH{1'b0}});
`else
                    ovf_d       = 1'b0;
`endif
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {SHW{1'b0}};
            acc_hi_q    <= {WIDTH{1'b0}};
            acc_lo_q    <= {WIDTH{1'b0}};
            opd_q       <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_DIV_EN
            op_div_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opd_q       <= opd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
`ifdef ALU_DIV_EN
            op_div_q    <= op_div_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = illegal_q;

endmodule
